pipeline_hazard_ctrl: RTL and testbench

Central sequencing controller for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB). It keeps a scoreboard of in-flight register writes, stalls IF/ID and inserts EX bubbles on read-after-write hazards, and generates the branch/jump flush. It also drains the pipeline cleanly when the terminate instruction reaches ID, then asserts the CPU-terminate pulse. The datapath has no forwarding, so this block is the sole source of stall and flush control for all stages.

---
 rtl/pipeline_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flush/halt sequencer for the 5-stage CPU: tracks in-flight register
// writes, stalls on RAW hazards, flushes on taken branches and drains on halt.
module pipeline_hazard_ctrl #(
  parameter int unsigned SB_DEPTH = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             id_valid,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_reg_write,
  input  logic [4:0]       id_wb_addr,
  input  logic             id_halt,
  input  logic             pc_src_m,
  output logic             stall_f,
  output logic             stall_d,
  output logic             bubble_e,
  output logic             flush,
  output logic             terminate,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t             r_state;
  logic [SB_DEPTH-1:0] r_sb_v;
  logic [REG_W-1:0]   r_sb_addr [SB_DEPTH];
  logic               r_terminate;
  logic               r_halted;
  logic [CNT_W-1:0]   r_stall_count;
  logic [CNT_W-1:0]   r_flush_count;

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_run;
  logic w_hazard;
  logic w_flush;
  logic w_stall;
  logic w_issue;
  logic w_halt_go;
  logic w_sb_empty;

  // Source-vs-scoreboard match; WB entry counts since the regfile is not write-through
  always_comb begin
    w_rs_hit = 1'b0;
    w_rt_hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (r_sb_v[i] && (r_sb_addr[i] == id_rs_addr)) w_rs_hit = 1'b1;
      if (r_sb_v[i] && (r_sb_addr[i] == id_rt_addr)) w_rt_hit = 1'b1;
    end
  end

  assign w_run      = (r_state == RUN);
  assign w_hazard   = w_run && id_valid &&
                      ((id_rs_used && (id_rs_addr != REG_W'(0)) && w_rs_hit) ||
                       (id_rt_used && (id_rt_addr != REG_W'(0)) && w_rt_hit));
  assign w_flush    = pc_src_m && (r_state != HALT);
  assign w_stall    = w_run ? (w_hazard && !w_flush) : 1'b1;
  assign w_issue    = w_run && id_valid && !w_hazard && !w_flush && !id_halt;
  assign w_halt_go  = w_run && id_valid && id_halt && !w_hazard && !w_flush;
  assign w_sb_empty = ~|r_sb_v;

  assign stall_f     = w_stall;
  assign stall_d     = w_stall;
  assign bubble_e    = w_stall;
  assign flush       = w_flush;
  assign terminate   = r_terminate;
  assign halted      = r_halted;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

  // Sequencing FSM with registered terminate/halted
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= RUN;
      r_terminate <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_terminate <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_halt_go) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_flush) begin
            r_state <= RUN;
          end else if (w_sb_empty) begin
            r_state     <= HALT;
            r_terminate <= 1'b1;
            r_halted    <= 1'b1;
          end
        end
        HALT: begin
          r_halted <= 1'b1;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Scoreboard shift; a flush kills the instruction leaving EX
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sb_v <= '0;
      for (int i = 0; i < SB_DEPTH; i++) r_sb_addr[i] <= '0;
    end else begin
      r_sb_v[0]    <= w_issue && id_reg_write && (id_wb_addr != REG_W'(0));
      r_sb_addr[0] <= w_issue ? id_wb_addr : REG_W'(0);
      for (int i = 1; i < SB_DEPTH; i++) begin
        if ((i == 1) && w_flush) begin
          r_sb_v[i]    <= 1'b0;
          r_sb_addr[i] <= '0;
        end else begin
          r_sb_v[i]    <= r_sb_v[i-1];
          r_sb_addr[i] <= r_sb_addr[i-1];
        end
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_hazard && !w_flush && (r_stall_count != {CNT_W{1'b1}}))
        r_stall_count <= r_stall_count + CNT_W'(1);
      if (w_flush && (r_flush_count != {CNT_W{1'b1}}))
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic checked
// against a timeline model of in-flight writes (issue cycle -> live window).
module tb_pipeline_hazard_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        id_valid;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        id_reg_write;
  logic [4:0]  id_wb_addr;
  logic        id_halt;
  logic        pc_src_m;
  logic        stall_f;
  logic        stall_d;
  logic        bubble_e;
  logic        flush;
  logic        terminate;
  logic        halted;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  pipeline_hazard_ctrl #(.SB_DEPTH(3), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_reg_write(id_reg_write), .id_wb_addr(id_wb_addr),
    .id_halt(id_halt), .pc_src_m(pc_src_m),
    .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e), .flush(flush),
    .terminate(terminate), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a write issued at cycle t occupies EX/MEM/WB at t+1..t+3
  int       q_a [$];
  int       q_t [$];
  bit       q_k [$];
  int       cyc = 0;
  int       mode = 0;            // 0 run, 1 drain, 2 halt
  bit       exp_term = 0;
  bit       exp_halted = 0;
  bit [15:0] exp_stall_cnt = 0;
  bit [15:0] exp_flush_cnt = 0;

  bit g_stall, g_flush, g_term, g_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit live_match(input int a);
    for (int k = 0; k < q_a.size(); k++)
      if (!q_k[k] && (cyc - q_t[k] >= 1) && (cyc - q_t[k] <= 3) && ((a < 0) || (q_a[k] == a)))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q_a.delete(); q_t.delete(); q_k.delete();
    mode = 0; exp_term = 0; exp_halted = 0;
    exp_stall_cnt = '0; exp_flush_cnt = '0;
  endtask

  task automatic drive_idle();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_used = 0; id_rt_used = 0;
    id_reg_write = 0; id_wb_addr = 0; id_halt = 0; pc_src_m = 0;
  endtask

  task automatic step(input logic v, input logic [4:0] rs, input logic rsu,
                      input logic [4:0] rt, input logic rtu, input logic rw,
                      input logic [4:0] wb, input logic hl, input logic pc);
    bit hz, fl, st;
    @(negedge CLK);
    id_valid = v; id_rs_addr = rs; id_rs_used = rsu; id_rt_addr = rt; id_rt_used = rtu;
    id_reg_write = rw; id_wb_addr = wb; id_halt = hl; pc_src_m = pc;
    #1;
    hz = (mode == 0) && v && ((rsu && rs != 0 && live_match(int'(rs))) ||
                              (rtu && rt != 0 && live_match(int'(rt))));
    fl = pc && (mode != 2);
    st = (mode == 0) ? (hz && !fl) : 1'b1;
    chk("stall_f",  32'(stall_f),  32'(st));
    chk("stall_d",  32'(stall_d),  32'(st));
    chk("bubble_e", 32'(bubble_e), 32'(st));
    chk("flush",    32'(flush),    32'(fl));
    g_stall = stall_f; g_flush = flush;
    @(posedge CLK);
    if (mode == 0 && v && !hz && !fl && !hl && rw && wb != 0) begin
      q_a.push_back(int'(wb)); q_t.push_back(cyc); q_k.push_back(1'b0);
    end
    if (fl)
      for (int k = 0; k < q_t.size(); k++) if (q_t[k] == cyc - 1) q_k[k] = 1'b1;
    if (fl && exp_flush_cnt != 16'hFFFF) exp_flush_cnt++;
    if (mode == 0 && hz && !fl && exp_stall_cnt != 16'hFFFF) exp_stall_cnt++;
    exp_term = 0;
    case (mode)
      0: if (v && hl && !hz && !fl) mode = 1;
      1: if (fl) mode = 0;
         else if (!live_match(-1)) begin mode = 2; exp_term = 1; exp_halted = 1; end
      default: ;
    endcase
    cyc++;
    while (q_t.size() > 0 && q_t[0] < cyc - 4) begin
      void'(q_a.pop_front()); void'(q_t.pop_front()); void'(q_k.pop_front());
    end
    #1;
    chk("terminate",   32'(terminate),   32'(exp_term));
    chk("halted",      32'(halted),      32'(exp_halted));
    chk("stall_count", 32'(stall_count), 32'(exp_stall_cnt));
    chk("flush_count", 32'(flush_count), 32'(exp_flush_cnt));
    g_term = terminate; g_halted = halted;
  endtask

  task automatic idle(input logic pc);
    step(0, 0, 0, 0, 0, 0, 0, 0, pc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall_f"},  32'(stall_f),  0);
    chk({tag, "_stall_d"},  32'(stall_d),  0);
    chk({tag, "_bubble_e"}, 32'(bubble_e), 0);
    chk({tag, "_flush"},    32'(flush),    0);
    chk({tag, "_term"},     32'(terminate), 0);
    chk({tag, "_halted"},   32'(halted),   0);
    chk({tag, "_scnt"},     32'(stall_count), 0);
    chk({tag, "_fcnt"},     32'(flush_count), 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 0;
    drive_idle();
    #1;
    chk_all_zero("reset");
    model_reset();
    @(negedge CLK);
    RST_N = 1;
  endtask

  initial begin
    int n;
    RST_N = 0;
    drive_idle();
    do_reset();

    // RAW from EX/MEM/WB: expect 3/2/1 stall cycles
    for (int gap = 0; gap < 3; gap++) begin
      do_reset();
      step(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0);
      for (int g = 0; g < gap; g++) idle(0);
      n = 0;
      for (int k = 0; k < 10; k++) begin
        step(1, 5'd3, 1, 5'd1, 1, 1, 5'd4, 0, 0);
        if (!g_stall) break;
        n++;
      end
      chk("raw_stall_len", 32'(n), 32'(3 - gap));
      chk("raw_stall_cnt", 32'(stall_count), 32'(3 - gap));
    end

    // Register 0 is never tracked: no stall, and a following halt drains in 1 cycle
    do_reset();
    step(1, 5'd1, 1, 5'd2, 1, 1, 5'd0, 0, 0);
    step(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0, 0);
    chk("r0_nostall", 32'(g_stall), 0);
    step(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 0);
    idle(0);
    chk("r0_drain1", 32'(g_term), 1);

    // Flush in the same cycle as a hazard
    do_reset();
    step(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0);
    step(1, 5'd3, 1, 5'd1, 1, 1, 5'd4, 0, 1);
    chk("fh_flush", 32'(g_flush), 1);
    chk("fh_stall", 32'(g_stall), 0);
    chk("fh_fcnt",  32'(flush_count), 1);
    chk("fh_scnt",  32'(stall_count), 0);
    step(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 0);
    chk("fh_ex_killed", 32'(g_stall), 0);

    // Halt behind lw $5: 3 drain cycles, one terminate pulse, flush ignored in HALT
    do_reset();
    step(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 0, 0);
    step(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      idle(0);
      n++;
      if (g_term) break;
    end
    chk("drain_len", 32'(n), 3);
    idle(0);
    chk("term_pulse", 32'(g_term), 0);
    chk("halt_sticky", 32'(g_halted), 1);
    idle(1);
    chk("halt_noflush", 32'(g_flush), 0);
    chk("halt_stall", 32'(g_stall), 1);

    // Halt killed by a flush during DRAIN
    do_reset();
    step(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 0, 0);
    step(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 0);
    idle(0);
    chk("kill_drain_stall", 32'(g_stall), 1);
    idle(1);
    chk("kill_flush", 32'(g_flush), 1);
    for (int k = 0; k < 4; k++) begin
      idle(0);
      chk("kill_run", 32'(g_stall), 0);
      chk("kill_noterm", 32'(g_term), 0);
    end

    // Asynchronous reset mid-drain
    do_reset();
    step(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 0, 0);
    step(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 0);
    idle(0);
    drive_idle();
    #1;
    chk("mid_drain_pre", 32'(stall_f), 1);
    RST_N = 0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(negedge CLK);
    RST_N = 1;

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      if (mode == 2 && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 9) < 8),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
